// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default widths for the fetch control unit.
package fetch_ctrl_pkg;

   localparam int AW_DEF    = 8;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {IDLE, BOOT, RUN, HALTED} state_t;

   typedef enum logic [1:0] {BR_ALWAYS, BR_Z, BR_NZ, BR_C} br_type_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Control-to-fetch bus: the controller (master) drives start/branch/halt, the fetch unit returns its PC.
interface fetch_ctrl_if
   import fetch_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF
);

   logic          start;
   logic [AW-1:0] start_addr;
   logic          branch;
   logic [AW-1:0] target;
   logic          taken;
   logic          halt;
   logic [AW-1:0] pc;

   modport master (
      output start, start_addr, branch, target, taken, halt,
      input  pc
   );

   modport slave (
      input  start, start_addr, branch, target, taken, halt,
      output pc
   );

endinterface

// File: rtl/fetch_ctrl_unit_branch_cond_eval.sv
// Combinational branch condition: decides whether a branch of the given type fires under the ALU flags.
module branch_cond_eval
   import fetch_ctrl_pkg::*;
(
   input  br_type_t br_type,
   input  logic     flag_z,
   input  logic     flag_c,
   output logic     cond
);

   always_comb begin
      cond = 1'b0;
      case (br_type)
         BR_ALWAYS: cond = 1'b1;
         BR_Z:      cond = flag_z;
         BR_NZ:     cond = ~flag_z;
         BR_C:      cond = flag_c;
         default:   cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_ctrl_unit.sv
// Fetch control unit: boot sequencing, branch resolution, halt and squash generation.
// Optional taken-branch statistics counter enabled by defining BR_STATS_EN.
module fetch_ctrl_unit
   import fetch_ctrl_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic              f_clk,
   input  logic              f_rst_n,
   input  logic              go,
   input  logic [AW-1:0]     boot_addr,
   input  logic              br_valid,
   input  logic [1:0]        br_type,
   input  logic [AW-1:0]     br_offset,
   input  logic              flag_z,
   input  logic              flag_c,
   input  logic              halt_instr,
   fetch_ctrl_if.master      fbus,
   output logic              squash,
   output logic [CNT_W-1:0]  taken_cnt
);

   state_t        state_q, state_d;
   logic [AW-1:0] start_addr_q, start_addr_d;
   logic          squash_q, squash_d;
   logic          cond;
   logic          in_run;
   logic          taken_w;

   branch_cond_eval u_cond (
      .br_type (br_type_t'(br_type)),
      .flag_z  (flag_z),
      .flag_c  (flag_c),
      .cond    (cond)
   );

   assign in_run  = (state_q == RUN);
   assign taken_w = in_run & br_valid & cond & ~halt_instr;

   always_comb begin
      state_d      = state_q;
      start_addr_d = start_addr_q;
      squash_d     = taken_w;
      case (state_q)
         IDLE, HALTED: begin
            if (go) begin
               state_d      = BOOT;
               start_addr_d = boot_addr;
            end
         end
         BOOT:    state_d = RUN;
         RUN:     if (halt_instr) state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge f_clk) begin
      if (!f_rst_n) begin
         state_q      <= IDLE;
         start_addr_q <= '0;
         squash_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_addr_q <= start_addr_d;
         squash_q     <= squash_d;
      end
   end

   // Branch outputs are only meaningful while running; forced quiet elsewhere.
   assign fbus.start      = (state_q == BOOT);
   assign fbus.start_addr = start_addr_q;
   assign fbus.branch     = in_run & br_valid;
   assign fbus.target     = in_run ? (fbus.pc + br_offset) : '0;
   assign fbus.taken      = taken_w;
   assign fbus.halt       = (state_q == HALTED);
   assign squash          = squash_q;

`ifdef BR_STATS_EN
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   always_comb begin
      taken_cnt_d = taken_cnt_q;
      if ((state_q != BOOT) && (state_d == BOOT))
         taken_cnt_d = '0;
      else if (taken_w && (taken_cnt_q != {CNT_W{1'b1}}))
         taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge f_clk) begin
      if (!f_rst_n) taken_cnt_q <= '0;
      else          taken_cnt_q <= taken_cnt_d;
   end

   assign taken_cnt = taken_cnt_q;
`else
   assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Self-checking bench for fetch_ctrl_unit: directed scenarios then random traffic against a behavioural model.
module tb_fetch_ctrl_unit;

   localparam int AW    = 8;
   localparam int CNT_W = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   localparam int M_IDLE    = 0;
   localparam int M_BOOTING = 1;
   localparam int M_RUNNING = 2;
   localparam int M_HALTED  = 3;

   logic          f_clk = 1'b0;
   logic          f_rst_n;
   logic          go;
   logic [AW-1:0] boot_addr;
   logic          br_valid;
   logic [1:0]    br_type;
   logic [AW-1:0] br_offset;
   logic          flag_z;
   logic          flag_c;
   logic          halt_instr;
   logic          squash;
   logic [CNT_W-1:0] taken_cnt;

   fetch_ctrl_if #(.AW(AW)) fbus ();

   fetch_ctrl_unit #(.AW(AW), .CNT_W(CNT_W)) dut (
      .f_clk      (f_clk),
      .f_rst_n    (f_rst_n),
      .go         (go),
      .boot_addr  (boot_addr),
      .br_valid   (br_valid),
      .br_type    (br_type),
      .br_offset  (br_offset),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .halt_instr (halt_instr),
      .fbus       (fbus),
      .squash     (squash),
      .taken_cnt  (taken_cnt)
   );

   always #5 f_clk = ~f_clk;

   int checks = 0;
   int errors = 0;

   int m_mode;
   int m_saddr;
   bit m_squash;
   int m_cnt;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit rst_n_i, input bit go_i, input int boot_i,
                                input int pc_i, input bit bv_i, input int bt_i, input int off_i,
                                input bit z_i, input bit c_i, input bit hi_i);
      f_rst_n    = rst_n_i;
      go         = go_i;
      boot_addr  = boot_i[AW-1:0];
      fbus.pc    = pc_i[AW-1:0];
      br_valid   = bv_i;
      br_type    = bt_i[1:0];
      br_offset  = off_i[AW-1:0];
      flag_z     = z_i;
      flag_c     = c_i;
      halt_instr = hi_i;
   endtask

   function automatic bit condHolds(input int bt, input bit z, input bit c);
      case (bt)
         0:       return 1'b1;
         1:       return z;
         2:       return !z;
         default: return c;
      endcase
   endfunction

   function automatic int expectedCount();
`ifdef BR_STATS_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   // Checks the current cycle against the model, then advances the model across the next edge.
   task automatic stepAndCheck();
      bit running;
      bit exp_taken;
      int exp_target;
      #1;
      running    = (m_mode == M_RUNNING);
      exp_taken  = running && br_valid && condHolds(int'(br_type), flag_z, flag_c) && !halt_instr;
      exp_target = running ? ((int'(fbus.pc) + int'(br_offset)) % 256) : 0;

      checkOutput("start",      32'(fbus.start),      32'(m_mode == M_BOOTING));
      checkOutput("start_addr", 32'(fbus.start_addr), 32'(m_saddr));
      checkOutput("halt",       32'(fbus.halt),       32'(m_mode == M_HALTED));
      checkOutput("squash",     32'(squash),          32'(m_squash));
      checkOutput("taken_cnt",  32'(taken_cnt),       32'(expectedCount()));
      checkOutput("branch",     32'(fbus.branch),     32'(running && br_valid));
      checkOutput("target",     32'(fbus.target),     32'(exp_target));
      checkOutput("taken",      32'(fbus.taken),      32'(exp_taken));

      if (!f_rst_n) begin
         m_mode   = M_IDLE;
         m_saddr  = 0;
         m_squash = 1'b0;
         m_cnt    = 0;
      end else begin
         m_squash = exp_taken;
         if (exp_taken && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         case (m_mode)
            M_IDLE, M_HALTED: if (go) begin
               m_mode  = M_BOOTING;
               m_saddr = int'(boot_addr);
               m_cnt   = 0;
            end
            M_BOOTING: m_mode = M_RUNNING;
            default:   if (halt_instr) m_mode = M_HALTED;
         endcase
      end
      @(negedge f_clk);
   endtask

   initial begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge f_clk);
      m_mode = M_IDLE; m_saddr = 0; m_squash = 0; m_cnt = 0;

      // Reset state, then boot from 0x20.
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 1, 8'h20, 8'h00, 0, 0, 8'h00, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 0, 8'h00, 8'h20, 0, 0, 8'h00, 0, 0, 0); stepAndCheck();
      // Unconditional backward branch, then the squash pulse.
      applyStimulus(1, 0, 8'h00, 8'h30, 1, 0, 8'hF0, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 0, 8'h00, 8'h20, 0, 0, 8'h00, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 0, 8'h00, 8'h21, 0, 0, 8'h00, 0, 0, 0); stepAndCheck();
      // Conditional types.
      applyStimulus(1, 0, 8'h00, 8'h22, 1, 1, 8'h04, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 0, 8'h00, 8'h23, 1, 1, 8'h04, 1, 0, 0); stepAndCheck();
      applyStimulus(1, 0, 8'h00, 8'h27, 1, 3, 8'h02, 0, 1, 0); stepAndCheck();
      // Target wrap, then halt colliding with a taken branch.
      applyStimulus(1, 1, 8'h77, 8'hFE, 1, 0, 8'h05, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 0, 8'h00, 8'h03, 1, 0, 8'h10, 0, 0, 1); stepAndCheck();
      applyStimulus(1, 0, 8'h00, 8'h03, 1, 0, 8'h10, 0, 0, 0); stepAndCheck();
      // Restart from HALTED at 0x40; go held through BOOT and RUN.
      applyStimulus(1, 1, 8'h40, 8'h03, 0, 0, 8'h00, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 1, 8'h50, 8'h03, 0, 0, 8'h00, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 1, 8'h60, 8'h40, 0, 0, 8'h00, 0, 0, 0); stepAndCheck();
      // Three taken branches, then reset mid-run.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 8'h00, 8'h41 + i, 1, 0, 8'h08, 0, 0, 0); stepAndCheck();
      end
      applyStimulus(0, 0, 8'h00, 8'h50, 1, 0, 8'h08, 0, 0, 0); stepAndCheck();
      applyStimulus(1, 0, 8'h00, 8'h50, 1, 0, 8'h08, 0, 0, 0); stepAndCheck();

      // Random traffic with occasional resets, boots and halts.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 199) != 0,
                       $urandom_range(0, 5) == 0,
                       int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)),
                       $urandom_range(0, 1) == 1,
                       int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 255)),
                       $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1,
                       $urandom_range(0, 19) == 0);
         stepAndCheck();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
